// File: rtl/sdram_pattern_writer.sv
// Test-pattern frame writer for the SDRAM controller sys_* write port.
// Optional AUTO_REPEAT_EN: restart a new frame after every frame_done.
module sdram_pattern_writer #(
  parameter int                 H_DISP    = 640,
  parameter int                 V_DISP    = 480,
  parameter int                 DATA_W    = 24,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sys_ready,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] fg_color,
  input  logic [7:0]        divide_param,
  output logic              sys_load,
  output logic              sys_we,
  output logic [DATA_W-1:0] sys_data,
  output logic [ADDR_W-1:0] sys_addr,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = DATA_W / 3;
  localparam int XW = 16;
  localparam int YW = 16;
  localparam int BW = H_DISP / 8;

  localparam logic [XW-1:0] X_LAST = XW'(H_DISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_DISP - 1);
  localparam logic [XW-1:0] B_LAST = XW'(BW - 1);
  localparam logic [CW-1:0] F = '1;
  localparam logic [CW-1:0] Z = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_mode;
  logic [DATA_W-1:0] r_fg;
  logic [7:0]        r_div;
  logic [7:0]        r_cnt;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [XW-1:0]     r_bcnt;
  logic [2:0]        r_bar;
  logic [ADDR_W-1:0] r_ptr;

  logic              r_load;
  logic              r_we;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_eol;
  logic              w_last;
  logic [CW-1:0]     w_xy;
  logic [DATA_W-1:0] w_pix;

  assign sys_load   = r_load;
  assign sys_we     = r_we;
  assign sys_data   = r_data;
  assign sys_addr   = r_addr;
  assign busy       = r_busy;
  assign frame_done = r_done;

  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    w_eol  = (r_x == X_LAST);
    w_last = w_eol && (r_y == Y_LAST);
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_LOAD;
      end
      S_LOAD: w_next = S_WRITE;
      S_WRITE: begin
        w_tick = (r_cnt == 8'd0) && sys_ready;
        if (w_tick && w_last)
          w_next = S_DONE;
      end
      S_DONE: begin
`ifdef AUTO_REPEAT_EN
        w_next = S_LOAD;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pix = '0;
    w_xy  = CW'(r_x) + CW'(r_y);
    case (r_mode)
      3'd0: w_pix = r_fg;
      3'd1: begin
        unique case (r_bar)
          3'd0: w_pix = {F, F, F};
          3'd1: w_pix = {F, F, Z};
          3'd2: w_pix = {Z, F, F};
          3'd3: w_pix = {Z, F, Z};
          3'd4: w_pix = {F, Z, F};
          3'd5: w_pix = {F, Z, Z};
          3'd6: w_pix = {Z, Z, F};
          3'd7: w_pix = {Z, Z, Z};
        endcase
      end
      3'd2: w_pix = {CW'(r_x), CW'(r_y), w_xy};
      3'd3: begin
        if (r_x[5] ^ r_y[5])
          w_pix = r_fg;
      end
      3'd4: begin
        if (r_x[3:0] == 4'd0 || r_y[3:0] == 4'd0 ||
            r_x == X_LAST || r_y == Y_LAST)
          w_pix = r_fg;
      end
      default: w_pix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= '0;
      r_fg   <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_bcnt <= '0;
      r_bar  <= '0;
      r_ptr  <= '0;
      r_load <= 1'b0;
      r_we   <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_load <= (r_state == S_LOAD);
      r_we   <= w_tick;
      r_done <= (r_state == S_DONE);
      r_busy <= (w_next == S_LOAD) || (w_next == S_WRITE);
      if (r_state == S_LOAD) begin
        r_mode <= mode;
        r_fg   <= fg_color;
        r_div  <= divide_param;
        r_cnt  <= '0;
        r_x    <= '0;
        r_y    <= '0;
        r_bcnt <= '0;
        r_bar  <= '0;
        r_ptr  <= BASE_ADDR;
      end else if (r_state == S_WRITE) begin
        // cnt parks at 0 while the controller stalls
        if (r_cnt != 8'd0)
          r_cnt <= (r_cnt == r_div) ? 8'd0 : r_cnt + 8'd1;
        else if (w_tick)
          r_cnt <= (r_div == 8'd0) ? 8'd0 : 8'd1;
        if (w_tick) begin
          r_data <= w_pix;
          r_addr <= r_ptr;
          r_ptr  <= r_ptr + ADDR_W'(1);
          if (w_eol) begin
            r_x    <= '0;
            r_y    <= r_y + YW'(1);
            r_bcnt <= '0;
            r_bar  <= '0;
          end else begin
            r_x <= r_x + XW'(1);
            if (r_bcnt == B_LAST) begin
              r_bcnt <= '0;
              r_bar  <= r_bar + 3'd1;
            end else begin
              r_bcnt <= r_bcnt + XW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_pattern_writer.sv
// Bench for sdram_pattern_writer: frame model scoreboard plus
// directed timing, pacing, stall, restart and reset vectors.
module tb_sdram_pattern_writer;

  localparam int          HA = 8;
  localparam int          VA = 2;
  localparam logic [31:0] BA = 32'h100;
  localparam int          HB = 64;
  localparam int          VB = 20;
  localparam logic [31:0] BB = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_ready = 1'b1, a_start = 1'b0;
  logic [2:0]  a_mode = '0;
  logic [23:0] a_fg = '0;
  logic [7:0]  a_div = '0;
  logic        a_load, a_we, a_busy, a_done;
  logic [23:0] a_data;
  logic [31:0] a_addr;

  logic        b_ready = 1'b1, b_start = 1'b0;
  logic [2:0]  b_mode = '0;
  logic [23:0] b_fg = '0;
  logic [7:0]  b_div = '0;
  logic        b_load, b_we, b_busy, b_done;
  logic [23:0] b_data;
  logic [31:0] b_addr;

  sdram_pattern_writer #(
    .H_DISP(HA), .V_DISP(VA), .DATA_W(24), .ADDR_W(32), .BASE_ADDR(BA)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .sys_ready(a_ready), .start(a_start),
    .mode(a_mode), .fg_color(a_fg), .divide_param(a_div),
    .sys_load(a_load), .sys_we(a_we), .sys_data(a_data),
    .sys_addr(a_addr), .busy(a_busy), .frame_done(a_done)
  );

  sdram_pattern_writer #(
    .H_DISP(HB), .V_DISP(VB), .DATA_W(24), .ADDR_W(32), .BASE_ADDR(BB)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .sys_ready(b_ready), .start(b_start),
    .mode(b_mode), .fg_color(b_fg), .divide_param(b_div),
    .sys_load(b_load), .sys_we(b_we), .sys_data(b_data),
    .sys_addr(b_addr), .busy(b_busy), .frame_done(b_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int h, input int v,
                                      input int m, input logic [23:0] fg,
                                      input int x, input int y);
    case (m)
      0: return fg;
      1: begin
        case (x / (h / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2: return {8'(x), 8'(y), 8'(x + y)};
      3: return (((x / 32) + (y / 32)) % 2 == 1) ? fg : 24'h0;
      4: return (x % 16 == 0 || y % 16 == 0 || x == h - 1 || y == v - 1)
                ? fg : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  // frame-level reference: a frame begins on an accepted start
  int          ma_mode = 0, mb_mode = 0, ma_idx = 0, mb_idx = 0;
  logic [23:0] ma_fg = '0, mb_fg = '0;
  bit          ma_act = 0, mb_act = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ma_act = 0; ma_idx = 0;
      mb_act = 0; mb_idx = 0;
    end else begin
      if (a_we) begin
        chk("a_we_in_frame", 32'(ma_act), 32'd1);
        chk("a_addr", a_addr, BA + 32'(ma_idx));
        chk("a_data", 32'(a_data),
            32'(pix(HA, VA, ma_mode, ma_fg, ma_idx % HA, ma_idx / HA)));
        ma_idx++;
      end
      if (a_done) begin
        chk("a_frame_len", 32'(ma_idx), 32'(HA * VA));
        ma_idx = 0;
`ifdef AUTO_REPEAT_EN
        ma_mode = int'(a_mode); ma_fg = a_fg;
`else
        ma_act = 0;
`endif
      end
      if (a_start && !ma_act) begin
        ma_act = 1; ma_mode = int'(a_mode); ma_fg = a_fg; ma_idx = 0;
      end
      if (b_we) begin
        chk("b_we_in_frame", 32'(mb_act), 32'd1);
        chk("b_addr", b_addr, BB + 32'(mb_idx));
        chk("b_data", 32'(b_data),
            32'(pix(HB, VB, mb_mode, mb_fg, mb_idx % HB, mb_idx / HB)));
        mb_idx++;
      end
      if (b_done) begin
        chk("b_frame_len", 32'(mb_idx), 32'(HB * VB));
        mb_idx = 0;
`ifdef AUTO_REPEAT_EN
        mb_mode = int'(b_mode); mb_fg = b_fg;
`else
        mb_act = 0;
`endif
      end
      if (b_start && !mb_act) begin
        mb_act = 1; mb_mode = int'(b_mode); mb_fg = b_fg; mb_idx = 0;
      end
    end
  end

  task automatic start_a(input logic [2:0] m, input logic [23:0] fg,
                         input logic [7:0] d);
    @(posedge clk); #2;
    a_mode = m; a_fg = fg; a_div = d; a_start = 1'b1;
    @(posedge clk); #2;
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [2:0] m, input logic [23:0] fg,
                         input logic [7:0] d);
    @(posedge clk); #2;
    b_mode = m; b_fg = fg; b_div = d; b_start = 1'b1;
    @(posedge clk); #2;
    b_start = 1'b0;
  endtask

  // k counts edges from the one that samples start (k=0)
  task automatic run_a(input int budget, input int gap, input int drop_at,
                       output int nwe, output int bad, output int dropwe,
                       output int k_first, output int k_last,
                       output int k_done, output int k_load,
                       output logic busy3, output logic [23:0] cap);
    int k = -1;
    int last = -1;
    int drop = 0;
    bit dropped = 0;
    nwe = 0; bad = 0; dropwe = 0; k_first = -1; k_last = -1;
    k_done = -1; k_load = -1; busy3 = 1'b0; cap = '0;
    while (k_done < 0 && k < budget) begin
      @(negedge clk);
      k++;
      if (a_load) k_load = k;
      if (k == 3) busy3 = a_busy;
      if (drop > 0) begin
        if (a_we) dropwe++;
        drop--;
        if (drop == 0) a_ready = 1'b1;
      end
      if (a_we) begin
        if (gap > 0 && last >= 0 && k - last != gap) bad++;
        last = k;
        nwe++;
        if (k_first < 0) k_first = k;
        k_last = k;
        if (a_addr == 32'h10B) cap = a_data;
      end
      if (drop_at >= 0 && !dropped && nwe == drop_at) begin
        a_ready = 1'b0; drop = 10; dropped = 1;
      end
      if (a_done) k_done = k;
    end
    if (k_done < 0) chk("a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_b_pix(input logic [31:0] addr, input logic [23:0] expd,
                            input int budget);
    int n = 0;
    bit found = 0;
    while (!found && n < budget) begin
      @(negedge clk);
      n++;
      if (b_we && b_addr == addr) begin
        found = 1;
        chk($sformatf("b_pix@%0d", addr), 32'(b_data), 32'(expd));
      end
    end
    if (!found) chk($sformatf("b_pix@%0d_timeout", addr), 32'd0, 32'd1);
  endtask

  task automatic wait_b_done(input int budget);
    int n = 0;
    while (!b_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) chk("b_done_timeout", 32'd0, 32'd1);
  endtask

  int          nwe, bad, dropwe, kf, kl, kd, kld, cnt0, cnt1;
  logic        bz;
  logic [23:0] cap;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_load", 32'(a_load), 32'd0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_addr", a_addr, 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(b_done), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

`ifndef AUTO_REPEAT_EN
    // solid frame: exact cycle timeline
    start_a(3'd0, 24'h123456, 8'd0);
    run_a(100, 1, -1, nwe, bad, dropwe, kf, kl, kd, kld, bz, cap);
    chk("t1_load_cyc", 32'(kld), 32'd1);
    chk("t1_first_we", 32'(kf), 32'd2);
    chk("t1_last_we", 32'(kl), 32'd17);
    chk("t1_writes", 32'(nwe), 32'd16);
    chk("t1_gaps", 32'(bad), 32'd0);
    chk("t1_done_cyc", 32'(kd), 32'd18);
    chk("t1_busy_mid", 32'(bz), 32'd1);
    chk("t1_hold_addr", a_addr, 32'h10F);
    chk("t1_hold_data", 32'(a_data), 32'h123456);
    chk("t1_we_done", 32'(a_we), 32'd0);
    @(negedge clk);
    chk("t1_busy_19", 32'(a_busy), 32'd0);

    // gradient with divider: a write every 4th cycle
    start_a(3'd2, 24'h0, 8'd3);
    run_a(200, 4, -1, nwe, bad, dropwe, kf, kl, kd, kld, bz, cap);
    chk("t3_writes", 32'(nwe), 32'd16);
    chk("t3_gaps", 32'(bad), 32'd0);
    chk("t3_first_we", 32'(kf), 32'd2);
    chk("t3_pix_3_1", 32'(cap), 32'h030104);

    // controller stall for 10 cycles after 5 writes
    start_a(3'd2, 24'h0, 8'd0);
    run_a(200, 0, 5, nwe, bad, dropwe, kf, kl, kd, kld, bz, cap);
    chk("t4_writes", 32'(nwe), 32'd16);
    chk("t4_we_in_stall", 32'(dropwe), 32'd0);
    chk("t4_done_cyc", 32'(kd), 32'd28);

    // re-start and input changes right after LOAD are ignored
    start_a(3'd0, 24'hABCDEF, 8'd0);
    @(posedge clk); #2;
    a_start = 1'b1; a_mode = 3'd4; a_fg = 24'h0; a_div = 8'd5;
    @(posedge clk); #2;
    a_start = 1'b0;
    run_a(200, 1, -1, nwe, bad, dropwe, kf, kl, kd, kld, bz, cap);
    chk("t5_writes", 32'(nwe), 32'd16);
    chk("t5_gaps", 32'(bad), 32'd0);
    chk("t5_data", 32'(a_data), 32'hABCDEF);
    cnt0 = 0; cnt1 = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_load) cnt0++;
      if (a_busy) cnt1++;
    end
    chk("t5_no_reload", 32'(cnt0), 32'd0);
    chk("t5_idle", 32'(cnt1), 32'd0);

    // modes 5..7 are black
    start_a(3'd5, 24'hFFFFFF, 8'd0);
    run_a(100, 1, -1, nwe, bad, dropwe, kf, kl, kd, kld, bz, cap);
    chk("t6_writes", 32'(nwe), 32'd16);
    chk("t6_data", 32'(a_data), 32'h0);

    // colour bars, width 8 on the 64-wide instance
    start_b(3'd1, 24'h0, 8'd0);
    wait_b_pix(32'd0,  24'hFFFFFF, 20);
    wait_b_pix(32'd8,  24'hFFFF00, 20);
    wait_b_pix(32'd16, 24'h00FFFF, 20);
    wait_b_pix(32'd24, 24'h00FF00, 20);
    wait_b_pix(32'd32, 24'hFF00FF, 20);
    wait_b_pix(32'd40, 24'hFF0000, 20);
    wait_b_pix(32'd48, 24'h0000FF, 20);
    wait_b_pix(32'd56, 24'h000000, 20);
    wait_b_pix(32'd64, 24'hFFFFFF, 20);
    wait_b_done(2000);

    start_b(3'd3, 24'hC0FFEE, 8'd0);
    wait_b_pix(32'd0,  24'h0, 20);
    wait_b_pix(32'd31, 24'h0, 50);
    wait_b_pix(32'd32, 24'hC0FFEE, 20);
    wait_b_pix(32'd96, 24'hC0FFEE, 100);
    wait_b_done(2000);

    start_b(3'd4, 24'h112233, 8'd0);
    wait_b_pix(32'd1,    24'h112233, 20);
    wait_b_pix(32'd65,   24'h0, 100);
    wait_b_pix(32'd80,   24'h112233, 50);
    wait_b_pix(32'd127,  24'h112233, 100);
    wait_b_pix(32'd130,  24'h0, 20);
    wait_b_pix(32'd1221, 24'h112233, 1200);
    wait_b_done(2000);
`else
    // repeating frames: mode change takes effect on the next frame
    start_b(3'd0, 24'h00FF00, 8'd0);
    wait_b_pix(32'd32, 24'h00FF00, 50);
    repeat (300) @(negedge clk);
    b_mode = 3'd3;
    wait_b_done(2000);
    b_start = 1'b0;
    @(negedge clk);
    chk("r_reload", 32'(b_load), 32'd1);
    wait_b_pix(32'd0,  24'h0, 10);
    wait_b_pix(32'd32, 24'h00FF00, 100);
    wait_b_pix(32'd31 + 32'd64, 24'h0, 100);
    wait_b_done(2000);
    @(negedge clk);
    chk("r_reload2", 32'(b_load), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_rst_busy", 32'(b_busy), 32'd0);
    chk("r_rst_addr", b_addr, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cnt0 = 0;
    repeat (50) begin
      @(negedge clk);
      if (b_load || b_done || b_we) cnt0++;
    end
    chk("r_stopped", 32'(cnt0), 32'd0);
`endif

    // asynchronous reset mid-frame
    start_a(3'd0, 24'h55AA55, 8'd1);
    repeat (8) @(negedge clk);
    chk("t7_busy_pre", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_load", 32'(a_load), 32'd0);
    chk("t7_we", 32'(a_we), 32'd0);
    chk("t7_data", 32'(a_data), 32'd0);
    chk("t7_addr", a_addr, 32'd0);
    chk("t7_busy", 32'(a_busy), 32'd0);
    chk("t7_done", 32'(a_done), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cnt0 = 0; cnt1 = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_done) cnt0++;
      if (a_we) cnt1++;
    end
    chk("t7_no_done", 32'(cnt0), 32'd0);
    chk("t7_no_we", 32'(cnt1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
